priority_decoder: RTL and testbench

Clocked 3-to-8 decoder and request-vector reconstructor that converts encoded indices back into one-hot and accumulated mask form. Takes a stream of 3-bit codes, such as the `y` output of the 8-to-3 priority encoder, over a valid/ready handshake. For each code it emits a registered one-hot strobe and ORs that code into a frame mask. When it accepts a `last`-tagged code, it presents the reconstructed 8-bit request vector with a duplicate-code flag and a code count, and holds them until acknowledged.

---
 rtl/priority_decoder.sv | 134 +++++++++++++
 tb/tb_priority_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder.sv
// Clocked 3-to-8 decoder that emits a one-hot strobe per accepted code and
// rebuilds the frame's request vector, duplicate flag and code count.
module priority_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] code,
  input  logic       last,
  output logic [7:0] y,
  output logic       y_valid,
  output logic [7:0] mask,
  output logic       mask_valid,
  input  logic       mask_ack,
  output logic [3:0] count,
  output logic       dup_err
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned ONEHOT_W = 1 << CODE_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [ONEHOT_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                dup, dup_nxt;
  logic [ONEHOT_W-1:0] mask_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                dup_err_nxt, mask_valid_nxt;
  logic [ONEHOT_W-1:0] y_nxt;
  logic                y_valid_nxt;
  logic                accept;
  logic [ONEHOT_W-1:0] onehot;

  assign in_ready = en && (state != DONE);
  assign accept   = in_valid && in_ready;
  assign onehot   = ONEHOT_W'(1) << code;

  // Next-state, accumulator and frame-result logic
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    cnt_nxt        = cnt;
    dup_nxt        = dup;
    mask_nxt       = mask;
    count_nxt      = count;
    dup_err_nxt    = dup_err;
    mask_valid_nxt = mask_valid;
    y_nxt          = accept ? onehot : '0;
    y_valid_nxt    = accept;

    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = onehot;
          cnt_nxt   = CNT_W'(1);
          dup_nxt   = 1'b0;
          state_nxt = last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt = acc | onehot;
          cnt_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
          dup_nxt = dup | acc[code];
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        if (mask_ack) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          dup_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        dup_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    // Frame results are loaded with the same values the accumulators take
    if (accept && last) begin
      mask_nxt       = acc_nxt;
      count_nxt      = cnt_nxt;
      dup_err_nxt    = dup_nxt;
      mask_valid_nxt = 1'b1;
    end else if ((state == DONE) && mask_ack) begin
      mask_nxt       = '0;
      count_nxt      = '0;
      dup_err_nxt    = 1'b0;
      mask_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      dup        <= 1'b0;
      y          <= '0;
      y_valid    <= 1'b0;
      mask       <= '0;
      count      <= '0;
      dup_err    <= 1'b0;
      mask_valid <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      dup        <= dup_nxt;
      y          <= y_nxt;
      y_valid    <= y_valid_nxt;
      mask       <= mask_nxt;
      count      <= count_nxt;
      dup_err    <= dup_err_nxt;
      mask_valid <= mask_valid_nxt;
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Bench for priority_decoder: directed frames plus random traffic, checked
// against a frame-level model that keeps the accepted codes in a queue.
module tb_priority_decoder;

  logic       clk, rst, en, in_valid, in_ready, last, mask_valid, mask_ack;
  logic       y_valid, dup_err;
  logic [2:0] code;
  logic [7:0] y, mask;
  logic [3:0] count;

  int total, bad;

  // Model state
  int         frame_q[$];
  bit         m_done;
  logic [7:0] m_mask, m_y;
  logic [3:0] m_count;
  logic       m_dup, m_y_valid;

  priority_decoder dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .last(last), .y(y), .y_valid(y_valid), .mask(mask),
    .mask_valid(mask_valid), .mask_ack(mask_ack), .count(count),
    .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame result from the whole list of codes
  task automatic close_frame();
    int n;
    m_mask = '0;
    m_dup  = 1'b0;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      m_mask = m_mask | (8'd1 << frame_q[i]);
      for (int j = i + 1; j < n; j++)
        if (frame_q[i] == frame_q[j]) m_dup = 1'b1;
    end
    m_count = (n > 15) ? 4'd15 : 4'(n);
    frame_q.delete();
  endtask

  task automatic check_outputs();
    check("y", y, m_y);
    check("y_valid", y_valid, m_y_valid);
    check("mask_valid", mask_valid, m_done);
    check("mask", mask, m_done ? m_mask : 8'd0);
    check("count", count, m_done ? m_count : 4'd0);
    check("dup_err", dup_err, m_done ? m_dup : 1'b0);
  endtask

  task automatic step(input logic e, input logic v, input logic [2:0] c,
                      input logic l, input logic a);
    bit will_accept, done_before;
    @(negedge clk);
    en = e; in_valid = v; code = c; last = l; mask_ack = a;
    #1;
    check("in_ready", in_ready, e && !m_done);
    will_accept = v && e && !m_done;
    done_before = m_done;
    @(posedge clk);
    #1;
    if (will_accept) begin
      m_y = 8'd1 << c;
      m_y_valid = 1'b1;
      frame_q.push_back(int'(c));
      if (l) begin
        close_frame();
        m_done = 1'b1;
      end
    end else begin
      m_y = '0;
      m_y_valid = 1'b0;
    end
    if (done_before && a) m_done = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b1; in_valid = 1'b0; last = 1'b0; mask_ack = 1'b0; code = '0;
    rst = 1'b1;
    #1;
    frame_q.delete();
    m_done = 1'b0; m_y = '0; m_y_valid = 1'b0;
    m_mask = '0; m_count = '0; m_dup = 1'b0;
    check_outputs();
    check("rst_in_ready", in_ready, en);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Index of highest set bit: what the 8-to-3 priority encoder would output
  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) if (v[k]) r = 3'(k);
    return r;
  endfunction

  initial begin
    logic [7:0] rt_in [3];
    logic [7:0] rt_exp [3];
    total = 0; bad = 0;
    clk = 1'b0; rst = 1'b1;
    en = 1'b0; in_valid = 1'b0; code = '0; last = 1'b0; mask_ack = 1'b0;
    m_done = 1'b0; m_y = '0; m_y_valid = 1'b0;
    m_mask = '0; m_count = '0; m_dup = 1'b0;

    do_reset();

    // Reset mid-frame
    step(1, 1, 3'd6, 0, 0);
    step(1, 1, 3'd3, 0, 0);
    do_reset();
    step(1, 1, 3'd1, 1, 0);
    check("rst_frame_mask", mask, 8'b0000_0010);
    check("rst_frame_count", count, 4'd1);
    step(1, 0, 3'd0, 0, 1);

    // Single frame, back-to-back
    step(1, 1, 3'd5, 0, 0);
    check("sf_y0", y, 8'b0010_0000);
    step(1, 1, 3'd2, 0, 0);
    check("sf_y1", y, 8'b0000_0100);
    step(1, 1, 3'd0, 1, 0);
    check("sf_y2", y, 8'b0000_0001);
    check("sf_mask", mask, 8'b0010_0101);
    check("sf_count", count, 4'd3);
    check("sf_dup", dup_err, 1'b0);
    step(1, 0, 3'd0, 0, 0);
    step(1, 0, 3'd0, 0, 0);
    check("sf_hold", mask_valid, 1'b1);
    step(1, 0, 3'd0, 0, 1);

    // Duplicates and count saturation
    for (int i = 0; i < 17; i++) step(1, 1, 3'd7, (i == 16), 0);
    check("sat_mask", mask, 8'b1000_0000);
    check("sat_count", count, 4'd15);
    check("sat_dup", dup_err, 1'b1);
    step(1, 0, 3'd0, 0, 1);

    // Backpressure: ack and in_valid together in DONE
    step(1, 1, 3'd1, 1, 0);
    step(1, 1, 3'd4, 0, 1);
    check("bp_not_taken", y_valid, 1'b0);
    step(1, 1, 3'd4, 1, 0);
    check("bp_y", y, 8'b0001_0000);
    step(1, 0, 3'd0, 0, 1);

    // Enable gating mid-frame
    step(1, 1, 3'd3, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd5, 0, 1);
    step(1, 1, 3'd6, 1, 0);
    check("en_mask", mask, 8'b0100_1000);
    step(1, 0, 3'd0, 0, 1);

    // Round-trip through the encoder's view of each request vector
    rt_in[0] = 8'b0010_0101; rt_exp[0] = 8'b0010_0000;
    rt_in[1] = 8'b0000_1100; rt_exp[1] = 8'b0000_1000;
    rt_in[2] = 8'b0000_0001; rt_exp[2] = 8'b0000_0001;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, enc(rt_in[i]), 1, 0);
      check("rt_mask", mask, rt_exp[i]);
      step(1, 0, 3'd0, 0, 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
